// File: rtl/hwpe_stream_package.sv
// Shared types for the HWPE stream TCDM blocks.
// Holds the state encoding of the TCDM reorder-stage order sequencer.
package hwpe_stream_package;

    // RUN: traffic flows; DRAIN: upstream gated, waiting on responses;
    // SWITCH: one cycle in which the pending order is committed.
    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        SWITCH = 2'd2
    } hwpe_stream_tcdm_reorder_ctrl_state_t;

endpackage

// File: rtl/hwpe_stream_tcdm_outstanding_cnt.sv
// Single-channel outstanding-transaction counter.
// Counts up on an accepted grant and down on a response. Both in the same
// cycle leave it unchanged. It saturates at MAX_OUTSTANDING. A response
// seen at zero holds the count at zero and raises underflow_o.
// Ports:
//   clk_i        clock
//   clear_i      synchronous clear (reset or soft clear)
//   inc_i        grant accepted this cycle
//   dec_i        response seen this cycle
//   cnt_o        current count (registered)
//   cnt_next_o   count after this edge
//   below_max_o  count < MAX_OUTSTANDING
//   underflow_o  response with nothing outstanding (combinational)
module hwpe_stream_tcdm_outstanding_cnt #(
    parameter int unsigned MAX_OUTSTANDING = 8,
    parameter int unsigned CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic             clk_i,
    input  logic             clear_i,
    input  logic             inc_i,
    input  logic             dec_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic [CNT_W-1:0] cnt_next_o,
    output logic             below_max_o,
    output logic             underflow_o
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic             underflow;

    always_comb begin
        cnt_d     = cnt_q;
        underflow = 1'b0;
        unique case ({inc_i, dec_i})
            2'b10: if (cnt_q != MAX_CNT) cnt_d = cnt_q + CNT_W'(1);
            2'b01: begin
                if (cnt_q == '0) underflow = 1'b1;
                else             cnt_d     = cnt_q - CNT_W'(1);
            end
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (clear_i) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end

    assign cnt_o       = cnt_q;
    assign cnt_next_o  = cnt_d;
    assign below_max_o = (cnt_q < MAX_CNT);
    assign underflow_o = underflow;

endmodule

// File: rtl/hwpe_stream_tcdm_reorder_ctrl.sv
// Runtime sequencer for the order_i vector of the static TCDM reorder stage.
// It tracks outstanding transactions per upstream channel. On a valid new
// order it gates upstream requests, waits until every channel has drained,
// then commits the new permutation. No response is ever routed with a stale
// order.
// Ports:
//   clk_i, rst_i, clear_i   clock, sync active-high reset, sync soft clear
//   order_i/_valid_i/_ready_o  requested permutation handshake
//   order_o                 committed permutation to the reorder stage
//   in_req_i/in_gnt_i/in_r_valid_i  upstream channel activity
//   req_enable_o            per-channel enable ANDed into upstream req/gnt
//   busy_o                  switch in progress
//   err_o                   one-cycle pulse: bad permutation or spurious r_valid
module hwpe_stream_tcdm_reorder_ctrl
    import hwpe_stream_package::*;
#(
    parameter int unsigned NB_CHAN         = 2,
    parameter int unsigned MAX_OUTSTANDING = 8
) (
    input  logic                                     clk_i,
    input  logic                                     rst_i,
    input  logic                                     clear_i,
    input  logic [NB_CHAN-1:0][$clog2(NB_CHAN)-1:0]  order_i,
    input  logic                                     order_valid_i,
    output logic                                     order_ready_o,
    output logic [NB_CHAN-1:0][$clog2(NB_CHAN)-1:0]  order_o,
    input  logic [NB_CHAN-1:0]                       in_req_i,
    input  logic [NB_CHAN-1:0]                       in_gnt_i,
    input  logic [NB_CHAN-1:0]                       in_r_valid_i,
    output logic [NB_CHAN-1:0]                       req_enable_o,
    output logic                                     busy_o,
    output logic                                     err_o
);

    localparam int unsigned IW    = $clog2(NB_CHAN);
    localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);

    hwpe_stream_tcdm_reorder_ctrl_state_t state_d, state_q;

    logic [NB_CHAN-1:0][IW-1:0]    order_d, order_q, pend_d, pend_q, ident;
    logic [NB_CHAN-1:0][CNT_W-1:0] cnt, cnt_next;
    logic [NB_CHAN-1:0]            below_max, underflow, cnt_inc;
    logic                          sync_clr, order_hs, perm_ok, err_d, err_q;
    logic [NB_CHAN-1:0]            seen;

    assign sync_clr = rst_i | clear_i;
    assign order_hs = order_valid_i & order_ready_o;

    // Per-channel counters. Only grants that actually pass the gate count.
    for (genvar i = 0; i < NB_CHAN; i++) begin : gen_cnt
        assign cnt_inc[i] = in_gnt_i[i] & in_req_i[i] & req_enable_o[i];

        hwpe_stream_tcdm_outstanding_cnt #(
            .MAX_OUTSTANDING (MAX_OUTSTANDING),
            .CNT_W           (CNT_W)
        ) i_cnt (
            .clk_i       (clk_i),
            .clear_i     (sync_clr),
            .inc_i       (cnt_inc[i]),
            .dec_i       (in_r_valid_i[i]),
            .cnt_o       (cnt[i]),
            .cnt_next_o  (cnt_next[i]),
            .below_max_o (below_max[i]),
            .underflow_o (underflow[i])
        );
    end

    always_comb begin
        ident = '0;
        for (int i = 0; i < NB_CHAN; i++) ident[i] = IW'(i);
    end

    // Valid permutation: every entry in range and no index repeated.
    // With NB_CHAN entries this means each index appears exactly once.
    always_comb begin
        perm_ok = 1'b1;
        seen    = '0;
        for (int i = 0; i < NB_CHAN; i++) begin
            if ({1'b0, order_i[i]} >= (IW + 1)'(NB_CHAN)) begin
                perm_ok = 1'b0;
            end else if (seen[order_i[i]]) begin
                perm_ok = 1'b0;
            end else begin
                seen[order_i[i]] = 1'b1;
            end
        end
    end

    // FSM: state register
    always_ff @(posedge clk_i) begin
        if (sync_clr) state_q <= RUN;
        else          state_q <= state_d;
    end

    // FSM: next state. DRAIN looks at the post-edge count so that it leaves
    // in the same cycle as the last response.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN:     if (order_hs && perm_ok) state_d = DRAIN;
            DRAIN:   if (cnt_next == '0)      state_d = SWITCH;
            SWITCH:  state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    // FSM: outputs, decoded from state and counts only
    always_comb begin
        order_ready_o = (state_q == RUN);
        busy_o        = (state_q != RUN);
        req_enable_o  = (state_q == RUN) ? below_max : '0;
    end

    always_comb begin
        pend_d  = pend_q;
        order_d = order_q;
        if (order_hs && perm_ok) pend_d  = order_i;
        if (state_q == SWITCH)   order_d = pend_q;
    end

    assign err_d = (order_hs & ~perm_ok) | (|underflow);

    always_ff @(posedge clk_i) begin
        if (sync_clr) begin
            order_q <= ident;
            pend_q  <= ident;
            err_q   <= 1'b0;
        end else begin
            order_q <= order_d;
            pend_q  <= pend_d;
            err_q   <= err_d;
        end
    end

    assign order_o = order_q;
    assign err_o   = err_q;

endmodule

// File: tb/tb_hwpe_stream_tcdm_reorder_ctrl.sv
// Directed bench for the TCDM reorder-order sequencer, NB_CHAN=4, MAX=8.
module tb_hwpe_stream_tcdm_reorder_ctrl;

    localparam int NB_CHAN = 4;
    localparam int MAXO    = 8;
    localparam logic [31:0] ID  = 32'hE4;  // {3,2,1,0} packed: order[i]=i
    localparam logic [31:0] REV = 32'h1B;  // order[0]=3 .. order[3]=0

    logic                  clk = 1'b0;
    logic                  rst_i, clear_i, order_valid_i, order_ready_o;
    logic [3:0][1:0]       order_i, order_o;
    logic [NB_CHAN-1:0]    in_req_i, in_gnt_i, in_r_valid_i, req_enable_o;
    logic                  busy_o, err_o;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    hwpe_stream_tcdm_reorder_ctrl #(
        .NB_CHAN         (NB_CHAN),
        .MAX_OUTSTANDING (MAXO)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .clear_i       (clear_i),
        .order_i       (order_i),
        .order_valid_i (order_valid_i),
        .order_ready_o (order_ready_o),
        .order_o       (order_o),
        .in_req_i      (in_req_i),
        .in_gnt_i      (in_gnt_i),
        .in_r_valid_i  (in_r_valid_i),
        .req_enable_o  (req_enable_o),
        .busy_o        (busy_o),
        .err_o         (err_o)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // advance one clock; inputs set after this are sampled at the next edge
    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst_i = 1; clear_i = 0; order_valid_i = 0; order_i = '0;
        in_req_i = '0; in_gnt_i = '0; in_r_valid_i = '0;
        tick(2);
        rst_i = 0;

        // reset state
        chk("rst_order",  32'(order_o), ID);
        chk("rst_ready",  32'(order_ready_o), 1);
        chk("rst_en",     32'(req_enable_o), 32'hF);
        chk("rst_busy",   32'(busy_o), 0);
        chk("rst_err",    32'(err_o), 0);

        // idle switch to reversed order, valid held into the first RUN cycle
        order_i = 8'h1B; order_valid_i = 1;
        tick();                                        // t+1
        chk("sw_busy1",  32'(busy_o), 1);
        chk("sw_en1",    32'(req_enable_o), 0);
        chk("sw_rdy1",   32'(order_ready_o), 0);
        tick();                                        // t+2
        chk("sw_busy2",  32'(busy_o), 1);
        chk("sw_en2",    32'(req_enable_o), 0);
        chk("sw_old",    32'(order_o), ID);
        tick();                                        // t+3
        chk("sw_new",    32'(order_o), REV);
        chk("sw_busy3",  32'(busy_o), 0);
        chk("sw_en3",    32'(req_enable_o), 32'hF);
        chk("sw_rdy3",   32'(order_ready_o), 1);
        tick();                                        // held valid accepted at t+3
        chk("hold_acc",  32'(busy_o), 1);
        order_valid_i = 0;
        tick(2);
        chk("hold_run",  32'(busy_o), 0);
        chk("hold_ord",  32'(order_o), REV);

        // channel 1: three outstanding, then switch back to identity
        in_req_i = 4'b0010; in_gnt_i = 4'b0010;
        tick(3);
        in_req_i = '0; in_gnt_i = '0;
        order_i = 8'hE4; order_valid_i = 1;            // handshake at t
        tick();                                        // t+1
        order_valid_i = 0;
        in_req_i = 4'hF; in_gnt_i = 4'hF;              // must be blocked
        chk("dr_en1",    32'(req_enable_o), 0);
        tick();                                        // t+2
        in_r_valid_i = 4'b0010;
        tick();                                        // t+3
        in_r_valid_i = 0;
        chk("dr_busy3",  32'(busy_o), 1);
        tick();                                        // t+4
        in_r_valid_i = 4'b0010;
        tick();                                        // t+5
        in_r_valid_i = 0;
        chk("dr_busy5",  32'(busy_o), 1);
        chk("dr_en5",    32'(req_enable_o), 0);
        tick();                                        // t+6
        in_r_valid_i = 4'b0010;
        chk("dr_busy6",  32'(busy_o), 1);
        tick();                                        // t+7: SWITCH
        in_r_valid_i = 0; in_req_i = 0; in_gnt_i = 0;
        chk("dr_sw_busy", 32'(busy_o), 1);
        chk("dr_sw_ord",  32'(order_o), REV);
        chk("dr_sw_err",  32'(err_o), 0);
        tick();                                        // t+8
        chk("dr_new",    32'(order_o), ID);
        chk("dr_run",    32'(busy_o), 0);
        chk("dr_err",    32'(err_o), 0);

        // invalid permutation {0,0,1,2}
        order_i = 8'h90; order_valid_i = 1;
        tick();
        order_valid_i = 0;
        chk("inv_err",   32'(err_o), 1);
        chk("inv_busy",  32'(busy_o), 0);
        chk("inv_ord",   32'(order_o), ID);
        tick();
        chk("inv_err0",  32'(err_o), 0);
        chk("inv_rdy",   32'(order_ready_o), 1);

        // channel 0 to the limit
        in_req_i = 4'b0001; in_gnt_i = 4'b0001;
        tick(MAXO);
        chk("sat_en",    32'(req_enable_o), 32'hE);
        tick();                                        // gated grant ignored
        chk("sat_hold",  32'(req_enable_o), 32'hE);
        in_req_i = 0; in_gnt_i = 0; in_r_valid_i = 4'b0001;
        tick();                                        // 7
        chk("sat_rel",   32'(req_enable_o), 32'hF);
        in_req_i = 4'b0001; in_gnt_i = 4'b0001;        // gnt+r_valid: stays 7
        tick(2);
        chk("sat_both",  32'(req_enable_o), 32'hF);
        in_r_valid_i = 0;
        tick();                                        // 8
        chk("sat_full",  32'(req_enable_o), 32'hE);
        in_req_i = 0; in_gnt_i = 0; in_r_valid_i = 4'b0001;
        tick(MAXO);                                    // back to 0
        in_r_valid_i = 0;
        chk("sat_noerr", 32'(err_o), 0);
        in_r_valid_i = 4'b0001;                        // spurious
        tick();
        in_r_valid_i = 0;
        chk("spur_err",  32'(err_o), 1);
        tick();
        chk("spur_err0", 32'(err_o), 0);

        // clear mid-DRAIN
        in_req_i = 4'b0100; in_gnt_i = 4'b0100;
        tick(2);
        in_req_i = 0; in_gnt_i = 0;
        order_i = 8'h1B; order_valid_i = 1;
        tick();
        order_valid_i = 0;
        chk("clr_pre",   32'(busy_o), 1);
        clear_i = 1;
        tick();
        clear_i = 0;
        chk("clr_busy",  32'(busy_o), 0);
        chk("clr_ord",   32'(order_o), ID);
        chk("clr_en",    32'(req_enable_o), 32'hF);
        chk("clr_err",   32'(err_o), 0);
        in_r_valid_i = 4'b0100;                        // counter 2 was cleared
        tick();
        in_r_valid_i = 0;
        chk("clr_cnt0",  32'(err_o), 1);
        tick(3);
        chk("clr_lost",  32'(order_o), ID);
        chk("clr_idle",  32'(busy_o), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/hwpe_stream_tcdm_reorder_ctrl.md
# hwpe_stream_tcdm_reorder_ctrl

Sequencer that owns the `order_i` vector of the static TCDM channel reorder stage and changes it safely at runtime. It sits beside the reorder stage on the upstream (in) side. It tracks outstanding transactions per channel: a transaction is outstanding once granted and until its `r_valid`. On a new-order request it gates upstream requests, drains all outstanding responses, then commits the new permutation. This guarantees that no response is routed with a stale order and that no request is issued during the switch.

## Interface
Parameters:
- `NB_CHAN`, 2: number of HWPE-Mem channels; must be ≥2.
- `MAX_OUTSTANDING`, 8: per-channel limit on granted-but-unanswered transactions; must be ≥1.

Ports (clock and reset first):
- `clk_i`  in  1  clock; all state updates on its rising edge.
- `rst_i`  in  1  synchronous, active-high reset.
- `clear_i`  in  1  synchronous soft clear; same effect as `rst_i`.
- `order_i`  in  NB_CHAN×$clog2(NB_CHAN)  requested permutation.
- `order_valid_i`  in  1  new order request.
- `order_ready_o`  out  1  request can be accepted.
- `order_o`  out  NB_CHAN×$clog2(NB_CHAN)  committed order; drives the reorder stage.
- `in_req_i`  in  NB_CHAN  upstream channel req, pre-gating.
- `in_gnt_i`  in  NB_CHAN  gnt returned by the reorder stage per upstream channel.
- `in_r_valid_i`  in  NB_CHAN  r_valid returned per upstream channel.
- `req_enable_o`  out  NB_CHAN  wrapper ANDs this into upstream req and gnt.
- `busy_o`  out  1  high in DRAIN or SWITCH.
- `err_o`  out  1  one-cycle pulse on a protocol or config error.

## Operation
- Per-channel counter `cnt[i]`, width $clog2(MAX_OUTSTANDING+1). Next value:
  - +1 on `in_gnt_i[i] & in_req_i[i] & req_enable_o[i]`.
  - −1 on `in_r_valid_i[i]`.
  - Both in the same cycle: unchanged.
- `r_valid` with `cnt[i]==0` and no same-cycle grant: counter holds at 0 and `err_o` pulses.
- `req_enable_o[i] = (state==RUN) & (cnt[i] < MAX_OUTSTANDING)`. A channel at the limit is throttled, and its counter never exceeds MAX_OUTSTANDING.
- Permutation check (combinational): `order_i` is valid iff every index 0..NB_CHAN-1 appears exactly once.
- FSM states: RUN, DRAIN, SWITCH.
  - RUN: `order_ready_o=1`.
    - Handshake with an invalid permutation: request dropped, `err_o` pulses next cycle, stay in RUN.
    - Handshake with a valid permutation: latch it into `pend_q`, go to DRAIN.
  - DRAIN: `order_ready_o=0`, all enables 0. When every `cnt[i]==0`, go to SWITCH.
  - SWITCH: `order_ready_o=0`, enables 0. `order_q <= pend_q`; go to RUN.
- `order_o = order_q`, registered; it changes only on the SWITCH→RUN edge.
- `rst_i` or `clear_i`, including mid-DRAIN:
  - state ← RUN; all counters ← 0.
  - `order_q` ← identity (`order_o[i]=i`); `pend_q` discarded.
  - `err_o` ← 0.

## Timing
- Reset values:
  - `order_ready_o=1`, `req_enable_o` all ones.
  - `order_o` identity.
  - `busy_o=0`, `err_o=0`.
- `order_ready_o`, `req_enable_o` and `busy_o` are decoded from state and `cnt` only, so they have no combinational path from `order_valid_i` or `order_i`.
- A grant in the handshake cycle t is still counted; enables drop at t+1.
- Minimum switch latency with nothing outstanding:
  - handshake at t;
  - DRAIN at t+1;
  - SWITCH at t+2;
  - new `order_o` and RUN at t+3.
- Each outstanding response extends DRAIN until the cycle after the last `r_valid` is seen.
- `order_valid_i` held high across a switch: the next request is accepted on the first RUN cycle (t+3).
- `err_o` is registered: one cycle after the offending event.

## Structure
- `hwpe_stream_package` gains `hwpe_stream_tcdm_reorder_ctrl_state_t` (RUN, DRAIN, SWITCH). No other package additions.
- One sub-module, `hwpe_stream_tcdm_outstanding_cnt`: a single-channel up/down counter with saturation, underflow flag and synchronous clear. Instantiated NB_CHAN times.
- Permutation check, FSM and the `order_q`/`pend_q` registers live in the top module.

## Test plan
- Reset, NB_CHAN=4 → `order_o`={0,1,2,3}, `order_ready_o=1`, `req_enable_o`=4'b1111, `busy_o=0`.
- Idle switch to {3,2,1,0}, handshake at t → `busy_o` high t+1..t+2, `order_o`={3,2,1,0} at t+3, enables 0 only at t+1 and t+2.
- Channel 1 with 3 grants outstanding, then switch, responses at t+2, t+4, t+6 → DRAIN until `cnt[1]==0`, SWITCH at t+7, new order at t+8, no request passes while enables are 0.
- Invalid order {0,0,1,2} → no state change, `err_o` pulses one cycle, `order_o` unchanged.
- Channel 0 at MAX_OUTSTANDING=8 → `req_enable_o[0]=0` until an `r_valid`; simultaneous gnt+`r_valid` keeps the count. A spurious `r_valid` at count 0 → `err_o` pulse.
- `clear_i` asserted mid-DRAIN → RUN next cycle, `order_o` identity, counters 0, pending order lost.
